// File: rtl/data_memory_bank_if.sv
// Load/store-side bus of the data memory bank: one byte-enabled write channel and one read channel.
// The load/store unit drives this bus through the master modport; the bank uses the slave modport.
interface data_memory_bank_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic                ready;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [DATA_W/8-1:0] wr_be;
  logic                wr_err;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;
  logic                rd_valid;
  logic [DATA_W-1:0]   rd_data;
  logic                rd_err;

  modport master (
    input  ready, wr_err, rd_valid, rd_data, rd_err,
    output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr
  );

  modport slave (
    output ready, wr_err, rd_valid, rd_data, rd_err,
    input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr
  );
endinterface

// File: rtl/data_memory_bank.sv
// Data memory bank: byte-enabled writes, 1- or 2-cycle registered reads, RDW policy,
// range checking and a post-reset zero sweep. INIT_FILE is consumed by the FPGA/sim init flow.
module data_memory_bank #(
  parameter int    DATA_W         = 16,
  parameter int    DEPTH          = 256,
  parameter int    ADDR_W         = 16,
  parameter int    RD_LAT         = 1,
  parameter int    RDW_MODE       = 1,
  parameter int    CLEAR_ON_RESET = 1,
  parameter string INIT_FILE      = "datamem.txt"
) (
  input logic               clk,
  input logic               rst,
  data_memory_bank_if.slave bus
);

  localparam int               NBE       = DATA_W / 8;
  localparam int               IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              wr_err_q, wr_err_d;
  logic              v1_q, v1_d, v2_q, v2_d;
  logic              err1_q, err1_d, err2_q, err2_d;
  logic [DATA_W-1:0] data1_q, data1_d, data2_q, data2_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_wdata;

  logic              wr_acc, rd_acc, wr_in_range, rd_in_range, rdw_hit;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic [DATA_W-1:0] wr_merged, rd_word;

  // Request decode; the same merged word feeds both the array write and the RDW bypass.
  always_comb begin
    wr_acc      = ready_q & bus.wr_en;
    rd_acc      = ready_q & bus.rd_en;
    wr_in_range = {1'b0, bus.wr_addr} < DEPTH_EXT;
    rd_in_range = {1'b0, bus.rd_addr} < DEPTH_EXT;
    wr_idx      = bus.wr_addr[IDX_W-1:0];
    rd_idx      = bus.rd_addr[IDX_W-1:0];
    rd_word     = mem[rd_idx];
    wr_merged   = mem[wr_idx];
    for (int i = 0; i < NBE; i++) begin
      if (bus.wr_be[i]) wr_merged[i*8 +: 8] = bus.wr_data[i*8 +: 8];
    end
    rdw_hit = (RDW_MODE != 0) && wr_acc && wr_in_range && (bus.wr_addr == bus.rd_addr);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_idx   = wr_idx;
    mem_wdata = wr_merged;
    case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_idx   = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) state_d = S_RUN;
      end
      S_RUN:   mem_we = wr_acc & wr_in_range;
      default: state_d = S_RUN;
    endcase
    ready_d  = (state_d == S_RUN);
    wr_err_d = wr_acc & ~wr_in_range;
    v1_d     = rd_acc;
    err1_d   = rd_acc & ~rd_in_range;
    data1_d  = '0;
    if (rd_acc && rd_in_range) data1_d = rdw_hit ? wr_merged : rd_word;
    v2_d     = v1_q;
    err2_d   = err1_q;
    data2_d  = data1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      wr_err_q <= 1'b0;
      v1_q     <= 1'b0;
      err1_q   <= 1'b0;
      data1_q  <= '0;
      v2_q     <= 1'b0;
      err2_q   <= 1'b0;
      data2_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      wr_err_q <= wr_err_d;
      v1_q     <= v1_d;
      err1_q   <= err1_d;
      data1_q  <= data1_d;
      v2_q     <= v2_d;
      err2_q   <= err2_d;
      data2_q  <= data2_d;
    end
  end

  // The array itself is never reset; a reset edge also suppresses the sweep write.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_idx] <= mem_wdata;
  end

  assign bus.ready    = ready_q;
  assign bus.wr_err   = wr_err_q;
  assign bus.rd_valid = (RD_LAT == 2) ? v2_q    : v1_q;
  assign bus.rd_err   = (RD_LAT == 2) ? err2_q  : err1_q;
  assign bus.rd_data  = (RD_LAT == 2) ? data2_q : data1_q;

endmodule

// File: tb/tb_data_memory_bank.sv
// Bench for data_memory_bank: two instances (RD_LAT=1/RDW new-data, RD_LAT=2/RDW old-data)
// share one stimulus stream and are checked every cycle against a word-array reference model.
module tb_data_memory_bank;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 16;
  localparam int NBE    = DATA_W / 8;
  localparam int LAT_A  = 1;
  localparam int LAT_B  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_memory_bank_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_a ();
  data_memory_bank_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_b ();

  data_memory_bank #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_LAT(LAT_A),
    .RDW_MODE(1), .CLEAR_ON_RESET(1), .INIT_FILE("datamem.txt")
  ) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave)
  );

  data_memory_bank #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_LAT(LAT_B),
    .RDW_MODE(0), .CLEAR_ON_RESET(1), .INIT_FILE("datamem.txt")
  ) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave)
  );

  typedef struct {
    int                due;
    logic [DATA_W-1:0] data;
    logic              err;
  } resp_t;

  logic [DATA_W-1:0] model_mem [DEPTH];
  resp_t             q_a[$];
  resp_t             q_b[$];
  int                clear_left;
  bit                exp_ready;
  bit                exp_wr_err;
  int                cycle;
  int                checks;
  int                passes;

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                              input logic [DATA_W-1:0] wd,
                                              input logic [NBE-1:0]    be);
    logic [DATA_W-1:0] r;
    r = old;
    for (int i = 0; i < NBE; i++) if (be[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    return r;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s cycle=%0d observed=%h expected=%h", tag, cycle, obs, exp);
  endtask

  // Reference behaviour of one clock edge, written from the request/response rules.
  task automatic model_edge(input bit r, input bit we, input logic [ADDR_W-1:0] wa,
                            input logic [DATA_W-1:0] wd, input logic [NBE-1:0] be,
                            input bit re, input logic [ADDR_W-1:0] ra);
    bit                rin, win;
    logic [DATA_W-1:0] old_w, new_w;
    exp_wr_err = 1'b0;
    if (r) begin
      q_a.delete();
      q_b.delete();
      clear_left = DEPTH;
      exp_ready  = 1'b0;
    end else begin
      if (exp_ready) begin
        rin = int'(ra) < DEPTH;
        win = int'(wa) < DEPTH;
        if (re) begin
          old_w = rin ? model_mem[int'(ra)] : '0;
          new_w = (we && win && wa == ra) ? merge(old_w, wd, be) : old_w;
          q_a.push_back('{cycle + LAT_A - 1, rin ? new_w : '0, !rin});
          q_b.push_back('{cycle + LAT_B - 1, rin ? old_w : '0, !rin});
        end
        if (we) begin
          if (win) model_mem[int'(wa)] = merge(model_mem[int'(wa)], wd, be);
          else     exp_wr_err = 1'b1;
        end
      end
      if (clear_left > 0) begin
        model_mem[DEPTH - clear_left] = '0;
        clear_left--;
      end
      exp_ready = (clear_left == 0);
    end
  endtask

  task automatic check_cycle();
    resp_t             h;
    bit                ev;
    logic [DATA_W-1:0] ed;
    bit                ee;
    check_output("ready_a", 32'(bus_a.ready), 32'(exp_ready));
    check_output("ready_b", 32'(bus_b.ready), 32'(exp_ready));
    check_output("wr_err_a", 32'(bus_a.wr_err), 32'(exp_wr_err));
    check_output("wr_err_b", 32'(bus_b.wr_err), 32'(exp_wr_err));

    ev = 1'b0; ed = '0; ee = 1'b0;
    if (q_a.size() > 0 && q_a[0].due == cycle) begin
      h = q_a.pop_front(); ev = 1'b1; ed = h.data; ee = h.err;
    end
    check_output("rd_valid_a", 32'(bus_a.rd_valid), 32'(ev));
    check_output("rd_data_a", 32'(bus_a.rd_data), 32'(ed));
    check_output("rd_err_a", 32'(bus_a.rd_err), 32'(ee));

    ev = 1'b0; ed = '0; ee = 1'b0;
    if (q_b.size() > 0 && q_b[0].due == cycle) begin
      h = q_b.pop_front(); ev = 1'b1; ed = h.data; ee = h.err;
    end
    check_output("rd_valid_b", 32'(bus_b.rd_valid), 32'(ev));
    check_output("rd_data_b", 32'(bus_b.rd_data), 32'(ed));
    check_output("rd_err_b", 32'(bus_b.rd_err), 32'(ee));
  endtask

  task automatic apply_stimulus(input bit r, input bit we, input logic [ADDR_W-1:0] wa,
                                input logic [DATA_W-1:0] wd, input logic [NBE-1:0] be,
                                input bit re, input logic [ADDR_W-1:0] ra);
    rst           = r;
    bus_a.wr_en   = we;  bus_b.wr_en   = we;
    bus_a.wr_addr = wa;  bus_b.wr_addr = wa;
    bus_a.wr_data = wd;  bus_b.wr_data = wd;
    bus_a.wr_be   = be;  bus_b.wr_be   = be;
    bus_a.rd_en   = re;  bus_b.rd_en   = re;
    bus_a.rd_addr = ra;  bus_b.rd_addr = ra;
    @(posedge clk);
    cycle++;
    model_edge(r, we, wa, wd, be, re, ra);
    #1;
    check_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    apply_stimulus(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [NBE-1:0] be);
    apply_stimulus(1'b0, 1'b1, a, d, be, 1'b0, '0);
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a);
    apply_stimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, a);
  endtask

  task automatic wr_rd(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic [NBE-1:0] be, input logic [ADDR_W-1:0] ra);
    apply_stimulus(1'b0, 1'b1, a, d, be, 1'b1, ra);
  endtask

  // Mostly a small hot set for collisions, plus edge-of-range and arbitrary 16-bit addresses.
  function automatic logic [ADDR_W-1:0] pick_addr();
    int sel;
    sel = $urandom_range(0, 15);
    if (sel == 0)      return ADDR_W'($urandom);
    else if (sel == 1) return ADDR_W'(DEPTH - 1 + $urandom_range(0, 2));
    else               return ADDR_W'($urandom_range(0, 15));
  endfunction

  initial begin
    checks     = 0;
    passes     = 0;
    cycle      = 0;
    clear_left = 0;
    exp_ready  = 1'b0;
    exp_wr_err = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    $display("[TB] start");

    do_reset();
    idle(DEPTH);
    rd(16'd0); rd(16'd128); rd(16'd255);
    idle(3);

    wr(16'd5, 16'hABCD, 2'b11);
    wr(16'd5, 16'h12FF, 2'b01);
    rd(16'd5);
    idle(3);

    wr(16'd1, 16'h0011, 2'b11);
    wr(16'd2, 16'h0022, 2'b11);
    wr(16'd3, 16'h0033, 2'b11);
    rd(16'd1); rd(16'd2); rd(16'd3);
    idle(3);

    wr(16'd7, 16'h1111, 2'b11);
    wr_rd(16'd7, 16'h2222, 2'b11, 16'd7);
    rd(16'd7);
    wr_rd(16'd7, 16'h3344, 2'b10, 16'd7);
    wr(16'd7, 16'h5555, 2'b11);
    idle(3);

    wr(16'd0, 16'h5A5A, 2'b11);
    wr(16'h0100, 16'hFFFF, 2'b11);
    wr(16'h0100, 16'hFFFF, 2'b00);
    rd(16'd0);
    rd(16'hFFFF);
    rd(16'h0100);
    idle(3);

    rd(16'd5);
    do_reset();
    idle(DEPTH);
    rd(16'd5);
    idle(3);

    for (int i = 0; i < 400; i++) begin
      logic [ADDR_W-1:0] wa, ra;
      wa = pick_addr();
      ra = ($urandom_range(0, 3) == 0) ? wa : pick_addr();
      apply_stimulus(1'b0, 1'($urandom_range(0, 1)), wa, DATA_W'($urandom),
                     NBE'($urandom), 1'($urandom_range(0, 1)), ra);
    end
    idle(3);

    do_reset();
    idle(100);
    do_reset();
    idle(DEPTH);
    rd(16'd3);
    idle(3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/data_memory_bank.md
Name: data_memory_bank

Overview:
- Parametrised successor to the single-port data memory used by the RISC datapath.
- Provides one write channel with byte enables and one read channel with configurable registered latency (1 or 2 cycles).
- Adds a selectable read-during-write policy, out-of-range address detection, and a post-reset clear sweep with a ready indication.
- Sits between the load/store unit and the data array; it is the only owner of data memory contents.

Parameters:
- DATA_W, 16, data word width in bits; must be a multiple of 8.
- DEPTH, 256, number of words.
- ADDR_W, 16, address port width; DEPTH <= 2**ADDR_W.
- RD_LAT, 1, read latency in cycles; legal values are 1 and 2.
- RDW_MODE, 1, same-address read-during-write policy: 0 returns old data, 1 returns new (merged) data.
- CLEAR_ON_RESET, 1, 1 zero-fills the array after reset; 0 skips the sweep and keeps contents.
- INIT_FILE, "datamem.txt", binary image loaded at time zero (simulation and FPGA init only).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- ready  output  1  high when requests are accepted.
- wr_en  input  1  write request.
- wr_addr  input  ADDR_W  write word address.
- wr_data  input  DATA_W  write data.
- wr_be  input  DATA_W/8  byte enables; bit i covers data[8i+7:8i].
- rd_en  input  1  read request.
- rd_addr  input  ADDR_W  read word address.
- rd_valid  output  1  read response strobe.
- rd_data  output  DATA_W  read data; 0 whenever rd_valid is 0.
- rd_err  output  1  read address was out of range; qualified by rd_valid.
- wr_err  output  1  one-cycle pulse: an accepted write was out of range.

Behaviour:
- Reset (rst=1 at a clock edge):
  - ready, rd_valid, rd_err and wr_err go to 0; rd_data goes to 0.
  - The read pipeline is flushed and the clear counter is set to 0.
  - Array contents are not touched by rst itself.
- FSM states are CLEAR and RUN.
  - After rst deasserts: go to CLEAR if CLEAR_ON_RESET=1, otherwise go directly to RUN.
  - CLEAR: write 0 to word[cnt] and increment cnt each cycle. When cnt reaches DEPTH-1, that cycle writes word[DEPTH-1] and the next state is RUN. CLEAR lasts exactly DEPTH cycles.
  - rst asserted during CLEAR restarts the sweep from 0.
  - ready=1 only in RUN; it is a registered output.
- Request acceptance:
  - Requests are accepted only when ready=1.
  - wr_en and rd_en with ready=0 are ignored: no write, no response, no error.
- Writes:
  - Performed at the accepting edge.
  - For each i with wr_be[i]=1, byte i is updated; other bytes are unchanged.
  - wr_be=0 is a legal no-op and still performs the range check.
  - If wr_addr >= DEPTH, the write is dropped and wr_err=1 for the following cycle.
- Reads:
  - An accepted read produces rd_valid=1 exactly RD_LAT cycles after the accepting edge, for one cycle.
  - Back-to-back reads give back-to-back responses in order at full throughput.
  - If rd_addr >= DEPTH, rd_data=0 and rd_err=1 with that response.
- Read-during-write: when wr_en and rd_en are both accepted in the same cycle with the same in-range address:
  - RDW_MODE=0: the read returns the pre-write word.
  - RDW_MODE=1: the read returns the word with enabled bytes replaced by wr_data.
  - A write to the address of a read issued on an earlier cycle does not alter that read's data, including when RD_LAT=2.
- Address comparison uses the full ADDR_W bits. There is no wrap-around and no modulo aliasing.
- A reset in the middle of the pipeline discards any outstanding read response; rd_valid never pulses for a read accepted before rst.

Test Plan:
- Clear sweep, DEPTH=256, CLEAR_ON_RESET=1: pulse rst for 1 cycle -> ready=0 for exactly 256 cycles then 1; reading addresses 0, 128 and 255 returns 0x0000.
- Byte enables: write 0xABCD with be=2'b11 to addr 5, then 0x12FF with be=2'b01 to addr 5, then read addr 5 -> rd_data=0xABFF, RD_LAT cycles after the read.
- Latency and throughput, RD_LAT=2: reads to addrs 1, 2, 3 on consecutive cycles (holding 0x0011, 0x0022, 0x0033) -> rd_valid high for 3 consecutive cycles starting 2 cycles after the first read, with data 0x0011, 0x0022, 0x0033.
- Read-during-write: addr 7 holds 0x1111; in the same cycle write 0x2222 (be=2'b11) and read addr 7 -> RDW_MODE=0 gives 0x1111, RDW_MODE=1 gives 0x2222; a subsequent read gives 0x2222 in both modes.
- Out of range, DEPTH=256: write to addr 0x0100 -> wr_err pulses for 1 cycle and word 0 is unchanged; read addr 0xFFFF -> rd_valid=1, rd_err=1, rd_data=0.
- Reset mid-operation: issue a read with RD_LAT=2, then assert rst on the next cycle -> no rd_valid pulse, ready=0, and a new clear sweep runs.
